vending_machine_multi: RTL and testbench

Parametrised multi-product vending controller with an accumulating credit register, per-product prices, cancel/refund and coin-by-coin change dispensing. It is the successor to the fixed two-state, single-product vending FSM. It sits between the coin acceptor front end (one coin code per cycle) and the product/change dispensers (one-cycle pulses). All outputs are registered.

---
 rtl/vending_machine_multi.sv | 189 ++++++++++++++++++
 tb/tb_vending_machine_multi.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: accumulates coin credit, vends one of NUM_PROD products
// at per-product prices, refunds on cancel and pays change out one coin per cycle.
// Every output is a register. A change coin is emitted in the same registered cycle that
// the refund/change activity begins, so the cycle in which credit reaches zero is IDLE.
module vending_machine_multi #(
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned NUM_PROD   = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned COIN1_VAL  = 5,
    parameter int unsigned COIN2_VAL  = 10,
    parameter int unsigned COIN3_VAL  = 25,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {8'd65, 8'd40, 8'd25, 8'd15},
    parameter int unsigned MAX_CREDIT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                prod_valid,
    output logic [SEL_W-1:0]    prod_id,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic                sel_denied
);

    localparam int unsigned SumW = CREDIT_W + 1;
    localparam logic [CREDIT_W-1:0] Coin1 = CREDIT_W'(COIN1_VAL);
    localparam logic [CREDIT_W-1:0] Coin2 = CREDIT_W'(COIN2_VAL);
    localparam logic [CREDIT_W-1:0] Coin3 = CREDIT_W'(COIN3_VAL);
    localparam logic [SumW-1:0]     MaxSum = SumW'(MAX_CREDIT);

    typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                busy_q, busy_d;
    logic                prod_valid_q, prod_valid_d;
    logic [SEL_W-1:0]    prod_id_q, prod_id_d;
    logic                change_valid_q, change_valid_d;
    logic [1:0]          change_coin_q, change_coin_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_denied_q, sel_denied_d;

    logic [CREDIT_W-1:0] price;
    logic                sel_ok;
    logic [CREDIT_W-1:0] coin_val;
    logic [SumW-1:0]     coin_sum;
    logic                disp_valid;
    logic [1:0]          disp_code;
    logic [CREDIT_W-1:0] disp_rem;

    // Price of the currently selected product.
    always_comb begin
        price = '0;
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            if (32'(sel_id) == i) price = PRICES[i*CREDIT_W +: CREDIT_W];
        end
    end

    assign sel_ok = 32'(sel_id) < NUM_PROD;

    // Value of the inserted coin and the widened sum used for the saturation check.
    always_comb begin
        case (coin)
            2'd1:    coin_val = Coin1;
            2'd2:    coin_val = Coin2;
            2'd3:    coin_val = Coin3;
            default: coin_val = '0;
        endcase
        coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    end

    // Largest coin not exceeding the current credit; a sub-coin residue is simply dropped.
    always_comb begin
        disp_valid = 1'b0;
        disp_code  = 2'd0;
        disp_rem   = '0;
        if (credit_q >= Coin3) begin
            disp_valid = 1'b1;
            disp_code  = 2'd3;
            disp_rem   = credit_q - Coin3;
        end else if (credit_q >= Coin2) begin
            disp_valid = 1'b1;
            disp_code  = 2'd2;
            disp_rem   = credit_q - Coin2;
        end else if (credit_q >= Coin1) begin
            disp_valid = 1'b1;
            disp_code  = 2'd1;
            disp_rem   = credit_q - Coin1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        prod_valid_d   = 1'b0;
        prod_id_d      = '0;
        change_valid_d = 1'b0;
        change_coin_d  = 2'd0;
        coin_reject_d  = 1'b0;
        sel_denied_d   = 1'b0;

        unique case (state_q)
            StIdle, StCredit: begin
                if (cancel && (state_q == StCredit)) begin
                    coin_reject_d  = (coin != 2'd0);
                    sel_denied_d   = sel_valid;
                    change_valid_d = disp_valid;
                    change_coin_d  = disp_code;
                    credit_d       = disp_rem;
                    state_d        = (disp_rem != '0) ? StChange : StIdle;
                end else if (coin != 2'd0) begin
                    sel_denied_d = sel_valid;
                    if (coin_sum <= MaxSum) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = StCredit;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (sel_valid) begin
                    if (sel_ok && (credit_q >= price)) begin
                        credit_d     = credit_q - price;
                        prod_valid_d = 1'b1;
                        prod_id_d    = sel_id;
                        state_d      = StVend;
                    end else begin
                        sel_denied_d = 1'b1;
                    end
                end
            end
            StVend, StChange: begin
                coin_reject_d = (coin != 2'd0);
                sel_denied_d  = sel_valid;
                if (credit_q != '0) begin
                    change_valid_d = disp_valid;
                    change_coin_d  = disp_code;
                    credit_d       = disp_rem;
                    state_d        = (disp_rem != '0) ? StChange : StIdle;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StVend) || (state_d == StChange);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            credit_q       <= '0;
            busy_q         <= 1'b0;
            prod_valid_q   <= 1'b0;
            prod_id_q      <= '0;
            change_valid_q <= 1'b0;
            change_coin_q  <= 2'd0;
            coin_reject_q  <= 1'b0;
            sel_denied_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            busy_q         <= busy_d;
            prod_valid_q   <= prod_valid_d;
            prod_id_q      <= prod_id_d;
            change_valid_q <= change_valid_d;
            change_coin_q  <= change_coin_d;
            coin_reject_q  <= coin_reject_d;
            sel_denied_q   <= sel_denied_d;
        end
    end

    assign credit       = credit_q;
    assign busy         = busy_q;
    assign prod_valid   = prod_valid_q;
    assign prod_id      = prod_id_q;
    assign change_valid = change_valid_q;
    assign change_coin  = change_coin_q;
    assign coin_reject  = coin_reject_q;
    assign sel_denied   = sel_denied_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios followed by random traffic, every
// cycle compared against a credit/mode reference model built from the vending rules.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic [7:0] credit;
    logic       busy;
    logic       prod_valid;
    logic [1:0] prod_id;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       coin_reject;
    logic       sel_denied;

    vending_machine_multi dut (
        .clk          (clk),
        .rst          (rst),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .cancel       (cancel),
        .credit       (credit),
        .busy         (busy),
        .prod_valid   (prod_valid),
        .prod_id      (prod_id),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .coin_reject  (coin_reject),
        .sel_denied   (sel_denied)
    );

    always #5 clk = ~clk;

    // Reference model: credit in plain integers, mode 0 = accepting, 1 = just vended,
    // 2 = paying out change.
    int denom [4] = '{0, 5, 10, 25};
    int price [4] = '{15, 25, 40, 65};
    int m_credit;
    int m_mode;
    int e_credit, e_busy, e_prod_valid, e_prod_id;
    int e_change_valid, e_change_coin, e_coin_reject, e_sel_denied;

    int n_total = 0;
    int n_pass  = 0;

    task automatic pay_out();
        int code = 0;
        for (int k = 3; k >= 1; k--) begin
            if (code == 0 && denom[k] <= m_credit) code = k;
        end
        if (code != 0) begin
            e_change_valid = 1;
            e_change_coin  = code;
            m_credit       = m_credit - denom[code];
        end else begin
            m_credit = 0;
        end
        m_mode = (m_credit > 0) ? 2 : 0;
    endtask

    task automatic model_step(int c, int sv, int sid, int cn, int r);
        e_prod_valid = 0; e_prod_id = 0; e_change_valid = 0; e_change_coin = 0;
        e_coin_reject = 0; e_sel_denied = 0;
        if (r != 0) begin
            m_credit = 0;
            m_mode   = 0;
        end else if (m_mode != 0) begin
            e_coin_reject = (c != 0);
            e_sel_denied  = sv;
            if (m_credit > 0) pay_out();
            else m_mode = 0;
        end else if (cn != 0 && m_credit > 0) begin
            e_coin_reject = (c != 0);
            e_sel_denied  = sv;
            pay_out();
        end else if (c != 0) begin
            e_sel_denied = sv;
            if (m_credit + denom[c] <= 255) m_credit = m_credit + denom[c];
            else e_coin_reject = 1;
        end else if (sv != 0) begin
            if (m_credit >= price[sid]) begin
                m_credit     = m_credit - price[sid];
                m_mode       = 1;
                e_prod_valid = 1;
                e_prod_id    = sid;
            end else begin
                e_sel_denied = 1;
            end
        end
        e_credit = m_credit;
        e_busy   = (m_mode != 0);
    endtask

    task automatic chk(string tag, int got, int exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    endtask

    // One clock: drive inputs, advance model on the edge, compare all outputs 1 time unit later.
    task automatic step(int c, int sv, int sid, int cn, int r);
        coin      = 2'(c);
        sel_valid = (sv != 0);
        sel_id    = 2'(sid);
        cancel    = (cn != 0);
        rst       = (r != 0);
        @(posedge clk);
        model_step(c, sv, sid, cn, r);
        #1;
        chk("credit",       int'(credit),       e_credit);
        chk("busy",         int'(busy),         e_busy);
        chk("prod_valid",   int'(prod_valid),   e_prod_valid);
        chk("prod_id",      int'(prod_id),      e_prod_id);
        chk("change_valid", int'(change_valid), e_change_valid);
        chk("change_coin",  int'(change_coin),  e_change_coin);
        chk("coin_reject",  int'(coin_reject),  e_coin_reject);
        chk("sel_denied",   int'(sel_denied),   e_sel_denied);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        m_credit = 0;
        m_mode   = 0;
        // Reset state.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // Exact-price vend, no change.
        step(3, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        idle(2);
        // Vend with two change coins on consecutive cycles.
        step(3, 0, 0, 0, 0);
        step(3, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(3);
        // Insufficient credit, then cancel refund of a single coin.
        step(2, 0, 0, 0, 0);
        step(0, 1, 2, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(1);
        // Saturation boundary and coin rejected while refunding.
        for (int i = 0; i < 10; i++) step(3, 0, 0, 0, 0);
        step(3, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(2, 0, 0, 0, 0);
        idle(12);
        // Coin plus selection, then cancel + coin + selection together.
        step(3, 0, 0, 0, 0);
        step(3, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(2, 1, 1, 1, 0);
        idle(4);
        // Reset in the middle of a refund.
        for (int i = 0; i < 3; i++) step(3, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        idle(3);
        // Cancel with no credit does nothing; coin in the same cycle still counts.
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 1, 3, 0, 0);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int c, sv, sid, cn, r;
            c   = ($urandom_range(0, 99) < 45) ? int'($urandom_range(1, 3)) : 0;
            sv  = ($urandom_range(0, 99) < 25) ? 1 : 0;
            sid = int'($urandom_range(0, 3));
            cn  = ($urandom_range(0, 99) < 6) ? 1 : 0;
            r   = ($urandom_range(0, 199) == 0) ? 1 : 0;
            step(c, sv, sid, cn, r);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
